// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS cascaded digits of DIGIT_W bits, each wrapping at
// RADIX, with 74169-style control (sync load, active-low ENP/ENT, U/D,
// active-low ripple carry) and a sticky wrap flag.
module bcd_updown_counter #(
    parameter int DIGIT_W = 4,
    parameter int DIGITS  = 2,
    parameter int RADIX   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIGITS*DIGIT_W-1:0] d,
    input  logic                      load_n,
    input  logic                      enp_n,
    input  logic                      ent_n,
    input  logic                      up_dn,
    input  logic                      clr_wrap,
    output logic [DIGITS*DIGIT_W-1:0] q,
    output logic                      rco_n,
    output logic                      wrap
);

    localparam int N = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DIG_MAX  = DIGIT_W'(RADIX - 1);
    localparam logic [DIGIT_W-1:0] DIG_ZERO = DIGIT_W'(0);
    localparam logic [DIGIT_W-1:0] DIG_ONE  = DIGIT_W'(1);

    logic [N-1:0] q_r;
    logic [N-1:0] q_step_s;
    logic [N-1:0] q_next_s;
    logic         wrap_r;
    logic         wrap_next_s;
    logic         count_s;
    logic         top_carry_s;
    logic         term_s;

    // Counting needs both enables low and no load pending.
    assign count_s = load_n & ~enp_n & ~ent_n;

    // Ripple the carry (up) or borrow (down) from digit 0 to the top digit.
    always_comb begin : step_chain
        logic               cin;
        logic [DIGIT_W-1:0] dig;
        q_step_s = q_r;
        cin      = 1'b1;
        dig      = DIG_ZERO;
        for (int i = 0; i < DIGITS; i++) begin
            dig = q_r[i*DIGIT_W +: DIGIT_W];
            if (!cin) begin
                q_step_s[i*DIGIT_W +: DIGIT_W] = dig;
                cin = 1'b0;
            end else if (up_dn) begin
                // Out-of-range digits also collapse to zero with a carry.
                if (dig >= DIG_MAX) begin
                    q_step_s[i*DIGIT_W +: DIGIT_W] = DIG_ZERO;
                    cin = 1'b1;
                end else begin
                    q_step_s[i*DIGIT_W +: DIGIT_W] = dig + DIG_ONE;
                    cin = 1'b0;
                end
            end else begin
                if (dig == DIG_ZERO) begin
                    q_step_s[i*DIGIT_W +: DIGIT_W] = DIG_MAX;
                    cin = 1'b1;
                end else if (dig > DIG_MAX) begin
                    // Out-of-range digit snaps to the top legal value, no borrow.
                    q_step_s[i*DIGIT_W +: DIGIT_W] = DIG_MAX;
                    cin = 1'b0;
                end else begin
                    q_step_s[i*DIGIT_W +: DIGIT_W] = dig - DIG_ONE;
                    cin = 1'b0;
                end
            end
        end
        top_carry_s = cin;
    end

    // Terminal value: all digits at RADIX-1 going up, all zero going down.
    always_comb begin : terminal_detect
        term_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            term_s = term_s & (q_r[i*DIGIT_W +: DIGIT_W] == (up_dn ? DIG_MAX : DIG_ZERO));
        end
    end

    assign rco_n = ~(~ent_n & term_s);

    // Next count: load has priority over count, otherwise hold.
    always_comb begin : next_count
        q_next_s = q_r;
        if (!load_n) begin
            q_next_s = d;
        end else if (count_s) begin
            q_next_s = q_step_s;
        end else begin
            q_next_s = q_r;
        end
    end

    // Sticky wrap: a wrapping count edge sets it and beats a simultaneous clear.
    always_comb begin : next_wrap
        wrap_next_s = wrap_r;
        if (count_s && top_carry_s) begin
            wrap_next_s = 1'b1;
        end else if (clr_wrap) begin
            wrap_next_s = 1'b0;
        end else begin
            wrap_next_s = wrap_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= {N{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign q    = q_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a decade 2-digit instance and a
// binary 1-digit instance share control inputs; expectations are queued by the
// driver and checked by an independent monitor on each falling clock edge.
module tb_bcd_updown_counter;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       load_n;
    logic       enp_n;
    logic       ent_n;
    logic       up_dn;
    logic       clr_wrap;
    logic [7:0] q_dec;
    logic       rco_n_dec;
    logic       wrap_dec;
    logic [3:0] q_bin;
    logic       rco_n_bin;
    logic       wrap_bin;

    typedef struct {
        string      name;
        logic       sel;     // 0 = decade instance, 1 = binary instance
        logic [7:0] q;
        logic       wrap;
        logic       rco_n;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    bcd_updown_counter #(.DIGIT_W(4), .DIGITS(2), .RADIX(10)) dut_dec (
        .clk(clk), .rst_n(rst_n), .d(d), .load_n(load_n), .enp_n(enp_n),
        .ent_n(ent_n), .up_dn(up_dn), .clr_wrap(clr_wrap),
        .q(q_dec), .rco_n(rco_n_dec), .wrap(wrap_dec)
    );

    bcd_updown_counter #(.DIGIT_W(4), .DIGITS(1), .RADIX(16)) dut_bin (
        .clk(clk), .rst_n(rst_n), .d(d[3:0]), .load_n(load_n), .enp_n(enp_n),
        .ent_n(ent_n), .up_dn(up_dn), .clr_wrap(clr_wrap),
        .q(q_bin), .rco_n(rco_n_bin), .wrap(wrap_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each falling edge compare the oldest queued expectation.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       aw;
        logic       ar;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                aq = e.sel ? {4'h0, q_bin} : q_dec;
                aw = e.sel ? wrap_bin : wrap_dec;
                ar = e.sel ? rco_n_bin : rco_n_dec;
                n_checks++;
                if (aq !== e.q || aw !== e.wrap || ar !== e.rco_n) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h wrap=%b rco_n=%b, expected q=%h wrap=%b rco_n=%b",
                             e.name, aq, aw, ar, e.q, e.wrap, e.rco_n);
                end
            end
        end
    end

    task automatic push(input string nm, input logic sel, input logic [7:0] eq,
                        input logic ew, input logic er);
        exp_t e;
        e.name  = nm;
        e.sel   = sel;
        e.q     = eq;
        e.wrap  = ew;
        e.rco_n = er;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus; expectation is the state seen after the edge.
    task automatic apply(input string nm, input logic ld, input logic [7:0] dv,
                         input logic enp, input logic ent, input logic ud,
                         input logic clr, input logic sel, input logic [7:0] eq,
                         input logic ew, input logic er);
        load_n   = ld;
        d        = dv;
        enp_n    = enp;
        ent_n    = ent;
        up_dn    = ud;
        clr_wrap = clr;
        push(nm, sel, eq, ew, er);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Asynchronous reset pulse entirely between two rising edges.
    task automatic reset_pulse(input string nm, input logic ud, input logic ent,
                               input logic er);
        load_n   = 1'b1;
        enp_n    = 1'b1;
        ent_n    = ent;
        up_dn    = ud;
        clr_wrap = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(nm, 1'b0, 8'h00, 1'b0, er);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        d        = 8'h00;
        load_n   = 1'b1;
        enp_n    = 1'b1;
        ent_n    = 1'b1;
        up_dn    = 1'b1;
        clr_wrap = 1'b0;
        push("reset_state", 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        //     name                 ld    d      enp   ent   ud    clr   sel   q      wrap  rco_n
        apply("load_35",           1'b0, 8'h35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b1);
        apply("count_36",          1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h36, 1'b0, 1'b1);
        apply("count_37",          1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h37, 1'b0, 1'b1);
        reset_pulse("async_reset", 1'b1, 1'b0, 1'b1);
        apply("rco_down_zero",     1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        apply("load_39",           1'b0, 8'h39, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h39, 1'b0, 1'b1);
        apply("carry_40",          1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1);
        apply("borrow_39",         1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h39, 1'b0, 1'b1);
        apply("load_98",           1'b0, 8'h98, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h98, 1'b0, 1'b1);
        apply("up_to_99",          1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
        apply("up_wrap",           1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        apply("clr_after_up",      1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        apply("down_load_rco",     1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        apply("down_wrap",         1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b1);
        apply("clr_wrap",          1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        apply("enp_gate",          1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
        apply("ent_gate",          1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1);
        apply("load_over_enables", 1'b0, 8'h42, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1);
        apply("load_af",           1'b0, 8'hAF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAF, 1'b0, 1'b1);
        apply("illegal_up",        1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        apply("load_keeps_wrap",   1'b0, 8'hAF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAF, 1'b1, 1'b1);
        apply("clr_before_down",   1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAF, 1'b0, 1'b1);
        apply("illegal_down",      1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA9, 1'b0, 1'b1);
        // Binary instance (RADIX=16, one digit).
        apply("bin_load_f",        1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1);
        apply("bin_rco_f",         1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
        apply("bin_up_wrap",       1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        apply("bin_clr",           1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        apply("bin_reload_f",      1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1);
        apply("bin_set_wins",      1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        apply("bin_count_1",       1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);

        // Let the monitor drain; anything left unchecked is a failure.
        for (int i = 0; i < 4; i++) begin
            if (sb_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit synchronous up/down counter, the next generation of the team's 4-bit 74169-style binary counter. It cascades DIGITS digits of DIGIT_W bits, each wrapping at a programmable RADIX, so one instance covers binary, decade or any modulus up to 2^DIGIT_W. It keeps the 74169 control set (synchronous load, active-low ENP/ENT, U/D, active-low ripple carry) and adds a sticky wrap flag. It drops into the Tiny Tapeout top wrapper in place of the single 4-bit core.

## Interface
Parameters:
- DIGIT_W, 4: bits per digit.
- DIGITS, 2: number of cascaded digits; total width N = DIGITS*DIGIT_W.
- RADIX, 10: per-digit modulus, 2..2^DIGIT_W. Use RADIX=16 for plain binary.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  N  load data; digit i is d[i*DIGIT_W +: DIGIT_W].
- load_n  in  1  synchronous load, active low.
- enp_n  in  1  count enable P, active low.
- ent_n  in  1  count enable T, active low; also gates rco_n.
- up_dn  in  1  1 = count up, 0 = count down.
- clr_wrap  in  1  synchronous clear of wrap.
- q  out  N  count; digit i is q[i*DIGIT_W +: DIGIT_W]. Registered.
- rco_n  out  1  ripple carry, active low. Combinational from q, up_dn and ent_n.
- wrap  out  1  sticky wrap-around flag. Registered.

## Operation
- Priority at each rising clk edge: load_n=0, then count, then hold.
- Load: q <= d. Ignores enp_n and ent_n. Loads the value even if a digit is >= RADIX. wrap is unchanged by load.
- Count: occurs when load_n=1, enp_n=0 and ent_n=0. Otherwise q holds.
- Digit step up, with carry-in from the lower digit (digit 0 always receives carry-in):
  - If the digit is >= RADIX-1: digit <= 0 and carry-out=1.
  - Else: digit+1, carry-out=0.
- Digit step down, with borrow-in:
  - If the digit is 0: digit <= RADIX-1 and borrow-out=1.
  - If the digit is > RADIX-1: digit <= RADIX-1 and borrow-out=0.
  - Else: digit-1, borrow-out=0.
- A digit without carry/borrow-in holds.
- Terminal value: every digit == RADIX-1 when up_dn=1, and every digit == 0 when up_dn=0.
- rco_n = 0 iff ent_n=0 and q is at the terminal value. It is independent of enp_n and load_n, as on the 74169.
- wrap: set on a count edge where the top digit produces carry-out (up) or borrow-out (down).
  - clr_wrap=1 clears it.
  - Set and clear in the same cycle: set wins.
- up_dn may change on any cycle. The new direction applies at the next edge, and rco_n re-evaluates combinationally.

## Timing
- Reset: rst_n=0 forces q=0 and wrap=0 immediately, without waiting for clk, including mid-count or mid-load.
  - rco_n after reset follows its equation: it is 0 if up_dn=0 and ent_n=0, else 1.
- Registers release on the first rising clk edge after rst_n deasserts.
- Load-to-q latency: 1 cycle. Count step: 1 cycle per enabled edge, no pipeline.
- rco_n has zero-cycle latency from q, up_dn and ent_n. It is low during the cycle before the wrapping edge.
- wrap rises on the same edge that q wraps.

## Test plan
- Reset/async: count to q=8'h37, then pulse rst_n low between edges -> q=8'h00 and wrap=0 before the next edge. Then hold up_dn=1, ent_n=0 -> rco_n=1.
- Decade up wrap (RADIX=10): load 8'h98, count up 1 -> q=8'h99 with rco_n=0. Next edge -> q=8'h00, wrap=1, rco_n=1.
- Decade down wrap: load 8'h00 with up_dn=0, ent_n=0 -> rco_n=0. Count 1 -> q=8'h99, wrap=1. Assert clr_wrap -> wrap=0 next edge.
- Enable gating at q=8'h99, up: enp_n=1, ent_n=0 -> q holds and rco_n=0. ent_n=1 -> rco_n=1 and q holds. load_n=0 with d=8'h42 and both enables high -> q=8'h42.
- Illegal digits, RADIX=10: load 8'hAF, count up -> q=8'h00 and wrap=1. Load 8'hAF, count down -> q=8'hA9 and wrap unchanged.
- Binary mode (RADIX=16, DIGITS=1): load 4'hF, count up -> q=4'h0 and wrap=1. Simultaneous wrap and clr_wrap -> wrap=1.
